// File: rtl/seg7_scan_if.sv
// Display-side bundle for seg7_scan: BCD digits and controls in, multiplexed
// common-anode drive (active-low anodes/segments/dp) out.
interface seg7_scan_if;
   logic [3:0] d0;
   logic [3:0] d1;
   logic [3:0] d2;
   logic [3:0] d3;
   logic       tick;
   logic       colon_en;
   logic       lzb;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   modport master (
      output d0, d1, d2, d3, tick, colon_en, lzb,
      input  an, seg, dp
   );

   modport slave (
      input  d0, d1, d2, d3, tick, colon_en, lzb,
      output an, seg, dp
   );
endinterface

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner for mm:ss display with ghost
// blanking, leading-zero suppression, per-scan digit snapshot and blinking colon.
//
// state | meaning
// BLANK | first BLANK_CYCLES clocks of a slot, all anodes off
// DRIVE | remainder of the slot, anode idx on, segments from snapshot
module seg7_scan #(
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic          clk,
   input  logic          reset,
   seg7_scan_if.slave    bus
);
   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   // Down-counter holds REFRESH_DIV-1-k; DRV_GO is the count seen on the edge into DRIVE.
   localparam logic [CW-1:0] TOP    = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] DRV_GO = CW'(REFRESH_DIV - BLANK_CYCLES);

   typedef enum logic {BLANK, DRIVE} state_t;

   state_t          state;
   logic            run;
   logic [CW-1:0]   cnt;
   logic [1:0]      idx;
   logic            colon;
   logic [3:0][3:0] snap;

   logic            colon_nxt;
   logic [3:0]      lz;
   logic [6:0]      seg_nxt;
   logic            dp_nxt;

   function automatic logic [6:0] dec(input logic [3:0] v);
      case (v)
         4'd0:    dec = 7'b1000000;
         4'd1:    dec = 7'b1111001;
         4'd2:    dec = 7'b0100100;
         4'd3:    dec = 7'b0110000;
         4'd4:    dec = 7'b0011001;
         4'd5:    dec = 7'b0010010;
         4'd6:    dec = 7'b0000010;
         4'd7:    dec = 7'b1111000;
         4'd8:    dec = 7'b0000000;
         4'd9:    dec = 7'b0010000;
         default: dec = 7'b0111111;
      endcase
   endfunction

   always_comb begin
      colon_nxt = colon ^ bus.tick;
      lz        = 4'b0000;
      lz[3]     = bus.lzb && (snap[3] == 4'd0);
      lz[2]     = lz[3] && (snap[2] == 4'd0);
      lz[1]     = lz[2] && (snap[1] == 4'd0);
      seg_nxt   = lz[idx] ? 7'b1111111 : dec(snap[idx]);
      dp_nxt    = ~((idx == 2'd2) && bus.colon_en && colon_nxt);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= BLANK;
         run     <= 1'b0;
         cnt     <= '0;
         idx     <= 2'd0;
         colon   <= 1'b0;
         snap    <= '0;
         bus.an  <= 4'b1111;
         bus.seg <= 7'b1111111;
         bus.dp  <= 1'b1;
      end else begin
         colon <= colon_nxt;
         if (!run || cnt == '0) begin
            // Start of a new slot; the first edge after reset begins slot 0.
            run     <= 1'b1;
            cnt     <= TOP;
            state   <= BLANK;
            bus.an  <= 4'b1111;
            bus.seg <= 7'b1111111;
            bus.dp  <= 1'b1;
            if (!run || idx == 2'd3) begin
               idx  <= 2'd0;
               snap <= {bus.d3, bus.d2, bus.d1, bus.d0};
            end else begin
               idx  <= idx + 2'd1;
            end
         end else begin
            cnt <= cnt - 1'b1;
            if (state == DRIVE || cnt == DRV_GO) begin
               state   <= DRIVE;
               bus.an  <= ~(4'b0001 << idx);
               bus.seg <= seg_nxt;
               bus.dp  <= dp_nxt;
            end
         end
      end
   end
endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with an 8-clock slot and 2-clock ghost blank.
module tb_seg7_scan;
   logic clk;
   logic reset;
   int   vectors;
   int   errs;
   int   pos;

   seg7_scan_if bus();

   seg7_scan #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s pos=%0d observed=%b expected=%b", tag, pos, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      pos = (pos + 1) % 32;
   endtask

   task automatic set_d(input logic [3:0] a3, input logic [3:0] a2,
                        input logic [3:0] a1, input logic [3:0] a0);
      bus.d3 = a3; bus.d2 = a2; bus.d1 = a1; bus.d0 = a0;
   endtask

   task automatic run_check(input int n, input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0, input logic dpx);
      logic [6:0] sx;
      int slot;
      int k;
      for (int i = 0; i < n; i++) begin
         step();
         slot = pos / 8;
         k    = pos % 8;
         sx   = (slot == 3) ? s3 : (slot == 2) ? s2 : (slot == 1) ? s1 : s0;
         if (k < 2) begin
            chk("an_blank", {3'b000, bus.an}, 7'b0001111);
            chk("seg_blank", bus.seg, 7'b1111111);
            chk("dp_blank", {6'd0, bus.dp}, 7'd1);
         end else begin
            chk("an_drive", {3'b000, bus.an}, {3'b000, ~(4'b0001 << slot)});
            chk("seg_drive", bus.seg, sx);
            chk("dp_drive", {6'd0, bus.dp}, {6'd0, (slot == 2) ? dpx : 1'b1});
         end
      end
   endtask

   task automatic align_end();
      for (int i = 0; i < 40 && pos != 31; i++) step();
   endtask

   task automatic pulse_tick();
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
   endtask

   initial begin
      vectors = 0;
      errs    = 0;
      pos     = -1;
      reset   = 1'b1;
      bus.tick = 1'b0;
      bus.colon_en = 1'b0;
      bus.lzb = 1'b0;
      set_d(4'd3, 4'd2, 4'd1, 4'd0);
      #1;
      chk("reset_an", {3'b000, bus.an}, 7'b0001111);
      chk("reset_seg", bus.seg, 7'b1111111);
      chk("reset_dp", {6'd0, bus.dp}, 7'd1);
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hold_an", {3'b000, bus.an}, 7'b0001111);
      reset = 1'b0;
      pos = -1;

      // 3,2,1,0 with lzb off, two full scans
      run_check(32, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000, 1'b1);
      run_check(32, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000, 1'b1);

      // mid-scan change at slot 1 cycle 4 stays hidden until next scan
      run_check(13, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000, 1'b1);
      set_d(4'd5, 4'd2, 4'd1, 4'd9);
      run_check(19, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000, 1'b1);
      run_check(32, 7'b0010010, 7'b0100100, 7'b1111001, 7'b0010000, 1'b1);

      // leading-zero blanking
      bus.lzb = 1'b1;
      set_d(4'd0, 4'd0, 4'd0, 4'd7);
      run_check(32, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000, 1'b1);
      set_d(4'd0, 4'd0, 4'd5, 4'd0);
      run_check(32, 7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000, 1'b1);

      // invalid BCD dash, no blanking
      bus.lzb = 1'b0;
      set_d(4'd1, 4'hC, 4'd4, 4'd8);
      run_check(32, 7'b1111001, 7'b0111111, 7'b0011001, 7'b0000000, 1'b1);

      // colon: 3 ticks -> on, 4th -> off, 5th with colon_en=0 -> masked
      bus.colon_en = 1'b1;
      pulse_tick(); step(); pulse_tick(); step(); pulse_tick();
      align_end();
      run_check(32, 7'b1111001, 7'b0111111, 7'b0011001, 7'b0000000, 1'b0);
      pulse_tick();
      align_end();
      run_check(32, 7'b1111001, 7'b0111111, 7'b0011001, 7'b0000000, 1'b1);
      bus.colon_en = 1'b0;
      pulse_tick();
      align_end();
      run_check(32, 7'b1111001, 7'b0111111, 7'b0011001, 7'b0000000, 1'b1);

      // async reset in slot 2 DRIVE with colon on
      bus.colon_en = 1'b1;
      for (int i = 0; i < 40 && pos != 20; i++) step();
      chk("pre_reset_an", {3'b000, bus.an}, 7'b0001011);
      chk("pre_reset_dp", {6'd0, bus.dp}, 7'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("async_an", {3'b000, bus.an}, 7'b0001111);
      chk("async_seg", bus.seg, 7'b1111111);
      chk("async_dp", {6'd0, bus.dp}, 7'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      pos = -1;
      run_check(32, 7'b1111001, 7'b0111111, 7'b0011001, 7'b0000000, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
